piso_sched: RTL and testbench

Two-requester scheduler that owns the parallel-in/serial-out shifter. Each requester presents a parallel word with a request. The block arbitrates round-robin, loads the winning word into the shifter and sequences it out MSB-first, one bit per clock. It marks frame boundaries and can serialize back-to-back frames with no idle bit between them. It sits between the word-level producers and the single serial output lane.

---
 rtl/piso_sched_pkg.sv | 12 +
 rtl/piso_shift.sv | 29 ++
 rtl/piso_sched.sv | 100 ++++++++++
 tb/tb_piso_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// Shared types for the two-requester parallel-in/serial-out scheduler.
package piso_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/piso_shift.sv
// WIDTH-bit load/shift register, MSB-first, zero-fill on shift.
// Latency: loaded word's MSB visible the cycle after load.
// Backpressure: none; load has priority over shift.
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/piso_sched.sv
// Round-robin scheduler for two word requesters feeding one serial lane.
// Latency: first frame bit on sout the cycle after the capture edge; WIDTH cycles per frame.
// Backpressure: requests are held until gnt; only sampled when idle or on a frame's last bit.
module piso_sched
  import piso_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             sout,
  output logic             sframe,
  output logic             src,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_src;
  logic            src_q;
  logic            last_bit;
  logic            take;
  logic            pick_b;
  logic            shift_en;
  logic            msb;
  logic [WIDTH-1:0] win_data;

  assign last_bit = (state == SHIFT) && (cnt == LAST);
  assign take     = ((state == IDLE) || last_bit) && (req_a || req_b);
  // On a tie, B wins only if A was the previous owner.
  assign pick_b   = req_b && (!req_a || (last_src == SRC_A));
  assign win_data = pick_b ? data_b : data_a;
  assign shift_en = (state == SHIFT) && !last_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_src <= SRC_B;
      src_q    <= SRC_A;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
    end else begin
      gnt_a <= take && !pick_b;
      gnt_b <= take && pick_b;
      case (state)
        IDLE: begin
          if (take) begin
            state    <= SHIFT;
            cnt      <= '0;
            src_q    <= pick_b;
            last_src <= pick_b;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            cnt <= cnt + CW'(1);
          end else if (take) begin
            cnt      <= '0;
            src_q    <= pick_b;
            last_src <= pick_b;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (take),
    .shift (shift_en),
    .din   (win_data),
    .msb   (msb)
  );

  assign sframe = (state == SHIFT);
  assign done   = last_bit;
  assign sout   = sframe && msb;
  assign src    = src_q;

endmodule

// File: tb/tb_piso_sched.sv
// Directed-vector bench for piso_sched at WIDTH = 4.
module tb_piso_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0;
  logic [3:0] data_a = 4'h0;
  logic       gnt_a;
  logic       req_b = 1'b0;
  logic [3:0] data_b = 4'h0;
  logic       gnt_b;
  logic       sout;
  logic       sframe;
  logic       src;
  logic       done;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  piso_sched #(
    .WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .data_a (data_a),
    .gnt_a  (gnt_a),
    .req_b  (req_b),
    .data_b (data_b),
    .gnt_b  (gnt_b),
    .sout   (sout),
    .sframe (sframe),
    .src    (src),
    .done   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic s, input logic sf, input logic d,
                     input logic sr, input logic ga, input logic gb);
    check_eq({tag, ".sout"},   32'(sout),   32'(s));
    check_eq({tag, ".sframe"}, 32'(sframe), 32'(sf));
    check_eq({tag, ".done"},   32'(done),   32'(d));
    check_eq({tag, ".src"},    32'(src),    32'(sr));
    check_eq({tag, ".gnt_a"},  32'(gnt_a),  32'(ga));
    check_eq({tag, ".gnt_b"},  32'(gnt_b),  32'(gb));
  endtask

  task automatic idle(input string tag);
    check_eq({tag, ".sout"},   32'(sout),   32'(0));
    check_eq({tag, ".sframe"}, 32'(sframe), 32'(0));
    check_eq({tag, ".done"},   32'(done),   32'(0));
    check_eq({tag, ".gnt_a"},  32'(gnt_a),  32'(0));
    check_eq({tag, ".gnt_b"},  32'(gnt_b),  32'(0));
  endtask

  // Called just after a capture edge; checks the 4 frame cycles and advances past them.
  task automatic frame(input string tag, input logic [3:0] w, input logic sr,
                       input logic drop, input logic raise_b);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("%s.b%0d", tag, i), w[3-i], 1'b1, (i == 3), sr,
          (i == 0) && !sr, (i == 0) && sr);
      if (i == 0 && drop) begin
        if (sr) req_b = 1'b0;
        else    req_a = 1'b0;
      end
      if (i == 1 && raise_b) begin
        req_b  = 1'b1;
        data_b = 4'h1;
      end
      step();
    end
  endtask

  initial begin
    // Reset state, then a single A frame of 4'hC.
    step();
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    idle("s1.pre");
    req_a  = 1'b1;
    data_a = 4'hC;
    step();
    frame("s1", 4'hC, 1'b0, 1'b1, 1'b0);
    idle("s1.end");

    // Both held from reset: A, B, A back-to-back.
    rst    = 1'b0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_a = 4'hF;
    data_b = 4'h5;
    step();
    cyc("s2.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    frame("s2.f0", 4'hF, 1'b0, 1'b0, 1'b0);
    frame("s2.f1", 4'h5, 1'b1, 1'b0, 1'b0);
    req_b = 1'b0;
    frame("s2.f2", 4'hF, 1'b0, 1'b1, 1'b0);
    idle("s2.end");

    // B raised during the 2nd bit of an A frame follows with no gap.
    req_a  = 1'b1;
    data_a = 4'h6;
    step();
    frame("s3.a", 4'h6, 1'b0, 1'b1, 1'b1);
    frame("s3.b", 4'h1, 1'b1, 1'b1, 1'b0);
    idle("s3.end");

    // Asynchronous reset during bit 2 of 4'h7.
    req_a  = 1'b1;
    data_a = 4'h7;
    step();
    cyc("s4.b0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    req_a = 1'b0;
    step();
    cyc("s4.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    cyc("s4.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      idle($sformatf("s4.idle%0d", i));
    end

    // Zero word, 3 idle cycles, then 4'hA.
    req_a  = 1'b1;
    data_a = 4'h0;
    step();
    frame("s5.z", 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle($sformatf("s5.gap%0d", i));
      if (i == 2) begin
        req_a  = 1'b1;
        data_a = 4'hA;
      end
      step();
    end
    frame("s5.a", 4'hA, 1'b0, 1'b1, 1'b0);
    idle("s5.end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
